// File: rtl/phy_pkg.sv
// Shared constants and types for the serial TX path.
// Holds the byte/FIFO sizes, the TX state encoding and the FIFO pointer helper.
package phy_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int ENTRY_W    = BYTE_W + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/phy_tx_byte_fifo.sv
// Small byte FIFO feeding the serializer; each entry is {last, data}.
// Head is always visible; push into a full FIFO and pop from an empty one are ignored.
module phy_tx_byte_fifo
    import phy_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head,
    output logic [CNT_W-1:0]   o_count
);

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push && (r_count != CNT_W'(FIFO_DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/phy_tx_serialize.sv
// Byte-to-serial transmitter: MSB first, one bit per clock, back-to-back bytes
// without gaps, and a sticky underrun flag when a packet starves mid-stream.
//
// state | meaning
// IDLE  | line at IDLE_LEVEL, waiting for a byte in the FIFO
// SEND  | shifting a byte out, bit_cnt 0..7
module phy_tx_serialize
    import phy_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
)
(
    input  logic        clk_160mhz,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        clr_underrun,
    output logic        TX,
    output logic        busy,
    output logic        underrun
);

    tx_state_t          r_state;
    logic [BYTE_W-1:0]  r_shift;
    logic [2:0]         r_bit_cnt;
    logic               r_last;
    logic               r_tx;
    logic               r_busy;
    logic               r_underrun;

    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;

    assign in_ready     = (w_fifo_count != CNT_W'(FIFO_DEPTH));
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = !w_fifo_empty &&
                          ((r_state == IDLE) || ((r_state == SEND) && (r_bit_cnt == 3'd7)));

    phy_tx_byte_fifo u_fifo (
        .i_clk   (clk_160mhz),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  ({in_last, in_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk_160mhz) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_last     <= 1'b0;
            r_tx       <= IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_tx   <= IDLE_LEVEL;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift   <= w_head[BYTE_W-1:0];
                        r_last    <= w_head[BYTE_W];
                        r_tx      <= w_head[BYTE_W-1];
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (r_bit_cnt != 3'd7) begin
                        r_shift   <= r_shift << 1;
                        r_tx      <= r_shift[BYTE_W-2];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else if (w_pop) begin
                        r_shift   <= w_head[BYTE_W-1:0];
                        r_last    <= w_head[BYTE_W];
                        r_tx      <= w_head[BYTE_W-1];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_tx      <= IDLE_LEVEL;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                        // Placed after the clear so a same-edge set takes priority.
                        if (!r_last) begin
                            r_underrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign TX       = r_tx;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_phy_tx_serialize.sv
// Self-checking bench for phy_tx_serialize: per-byte vector table, bit scoreboard,
// and hand-written burst, collision and mid-byte reset sequences.
module tb_phy_tx_serialize;

    localparam logic IDLE_LEVEL = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       clr_underrun;
    logic       in_ready;
    logic       TX;
    logic       busy;
    logic       underrun;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    logic exp_q[$];

    int   busy_cycles;
    int   busy_runs;
    int   first_busy_cyc;
    int   ready_low;
    logic prev_busy;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       exp_ur;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] burst_data[4];
    logic       burst_last[4];

    phy_tx_serialize #(.IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk_160mhz   (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .clr_underrun (clr_underrun),
        .TX           (TX),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #3 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every cycle busy is high must carry the next expected bit.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (!prev_busy) begin
                    busy_runs++;
                    if (first_busy_cyc < 0) first_busy_cyc = cyc;
                end
                busy_cycles++;
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected_busy", busy, 1'b0);
                end else begin
                    chk("tx_bit", TX, exp_q.pop_front());
                end
            end else begin
                chk("tx_idle_level", TX, IDLE_LEVEL);
            end
            if (!in_ready) ready_low++;
            prev_busy = busy;
        end
    end

    task automatic clear_counts();
        busy_cycles    = 0;
        busy_runs      = 0;
        first_busy_cyc = -1;
        ready_low      = 0;
        prev_busy      = busy;
    endtask

    task automatic push_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic l, output int acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        chk("accept_ready", in_ready, 1'b1);
        push_bits(d);
        acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy || exp_q.size() != 0) && g < 300);
        chk({nm, " idle_timeout"}, (g < 300), 1'b1);
    endtask

    task automatic send_single(input logic [7:0] d, input logic l, input string nm);
        int acc;
        clear_counts();
        drive_byte(d, l, acc);
        wait_idle(nm);
        chk({nm, " latency"}, first_busy_cyc, acc + 1);
        chk({nm, " busy_cycles"}, busy_cycles, 8);
        chk({nm, " busy_runs"}, busy_runs, 1);
    endtask

    task automatic run_burst(input int n, input string nm, output int stalls);
        int idx   = 0;
        int guard = 0;
        stalls = 0;
        clear_counts();
        while (idx < n && guard < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = burst_data[idx];
            in_last  = burst_last[idx];
            if (in_ready) begin
                push_bits(burst_data[idx]);
                idx++;
            end else begin
                stalls++;
            end
            guard++;
        end
        chk({nm, " accept_timeout"}, (guard < 200), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle(nm);
        chk({nm, " busy_cycles"}, busy_cycles, 8 * n);
        chk({nm, " busy_runs"}, busy_runs, 1);
        chk({nm, " underrun"}, underrun, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("underrun_clr", underrun, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int stalls;

        vecs[0] = '{8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h81, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 1'b0};

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        clr_underrun = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset TX", TX, IDLE_LEVEL);
        chk("reset busy", busy, 1'b0);
        chk("reset underrun", underrun, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        reset = 1'b0;
        clear_counts();
        mon_en = 1'b1;

        // Single bytes, including starvation cases.
        for (int i = 0; i < 5; i++) begin
            send_single(vecs[i].data, vecs[i].last, "single");
            chk("single underrun", underrun, vecs[i].exp_ur);
            if (vecs[i].exp_ur) begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    chk("underrun_sticky", underrun, 1'b1);
                end
                pulse_clr();
            end
        end

        // Back-to-back three bytes: 24 contiguous bits, FIFO full for 7 cycles.
        burst_data[0] = 8'hFF; burst_last[0] = 1'b0;
        burst_data[1] = 8'h00; burst_last[1] = 1'b0;
        burst_data[2] = 8'hC3; burst_last[2] = 1'b1;
        run_burst(3, "burst3", stalls);
        chk("burst3 stalls", stalls, 0);
        chk("burst3 ready_low", ready_low, 7);

        // Four bytes held valid: the fourth waits for the first FIFO pop during SEND.
        burst_data[0] = 8'h5A; burst_last[0] = 1'b0;
        burst_data[1] = 8'h96; burst_last[1] = 1'b0;
        burst_data[2] = 8'hE7; burst_last[2] = 1'b0;
        burst_data[3] = 8'h3C; burst_last[3] = 1'b1;
        run_burst(4, "burst4", stalls);
        chk("burst4 stalls", stalls, 7);
        chk("burst4 ready_low", ready_low, 14);

        // Set/clear collision on the underrun edge.
        clear_counts();
        drive_byte(8'h81, 1'b0, acc);
        repeat (8) @(negedge clk);
        chk("collide pre underrun", underrun, 1'b0);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("collide underrun", underrun, 1'b1);
        chk("collide busy", busy, 1'b0);
        pulse_clr();

        // Mid-byte reset with a second byte queued; neither resumes afterwards.
        clear_counts();
        drive_byte(8'hF0, 1'b1, acc);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset TX", TX, IDLE_LEVEL);
        chk("midreset busy", busy, 1'b0);
        chk("midreset in_ready", in_ready, 1'b1);
        exp_q.delete();
        clear_counts();
        mon_en = 1'b1;
        repeat (12) @(negedge clk);
        chk("midreset no_resume", busy_cycles, 0);
        send_single(8'h0F, 1'b1, "after_reset");
        chk("after_reset underrun", underrun, 1'b0);

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
